// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word, L1 line and the physical-memory responder states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l1_line;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_array.sv
// Line storage for the physical-memory responder: one synchronous write port and one
// combinational read port sharing a single line index.
module pmem_array
  import lc3b_types::*;
#(
  parameter int unsigned LINES = 4096,
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  lc3b_l1_line      wdata,
  output lc3b_l1_line      rdata
);

  // Contents are deliberately not reset.
  lc3b_l1_line mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory model: accepts one line read/write at a time and answers
// with a single-cycle pmem_resp pulse LATENCY cycles after acceptance.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINES   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_l1_line pmem_wdata,
  output logic        pmem_resp,
  output lc3b_l1_line pmem_rdata,
  output logic        proto_error,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IdxW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [7:0]  CntLoad = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  pmem_state_t     state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            op_write_q;
  logic [IdxW-1:0] idx_q;
  lc3b_l1_line     wdata_q;
  lc3b_l1_line     rdata_q;
  lc3b_l1_line     array_rdata;
  logic            err_q;
  logic [15:0]     rd_cnt_q, wr_cnt_q;
  logic            accept, held, dropped, array_we;
  logic            unused_addr;

  assign unused_addr = ^pmem_address[3:0];

  assign accept  = (state_q == StIdle) && (pmem_read || pmem_write);
  assign held    = op_write_q ? pmem_write : pmem_read;
  assign dropped = ((state_q == StBusy) || (state_q == StResp)) && !held;
  // A reset landing on the edge that ends RESP must not commit the write.
  assign array_we = rst_n && (state_q == StResp) && op_write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pmem_read || pmem_write) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = CntLoad;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((accept && pmem_read && pmem_write) || dropped) begin
        err_q <= 1'b1;
      end
      if (state_q == StResp) begin
        if (op_write_q) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          rdata_q <= array_rdata;
          if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  // Transaction latch; a simultaneous read+write is serviced as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_write_q <= pmem_write;
      idx_q      <= pmem_address[IdxW+3:4];
      wdata_q    <= pmem_wdata;
    end
  end

  pmem_array #(
    .LINES (LINES),
    .IDX_W (IdxW)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  assign pmem_resp   = (state_q == StResp);
  assign pmem_rdata  = (pmem_resp && !op_write_q) ? array_rdata : rdata_q;
  assign proto_error = err_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench: a LATENCY=10 instance driven from a vector table with a read-data
// scoreboard, and a LATENCY=1 instance for back-to-back timing and counter saturation.
`timescale 1ns/1ps
module tb_pmem_responder;
  import lc3b_types::*;

  localparam int unsigned Lat10     = 10;
  localparam int          SatCycles = 131078;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  bit   done10 = 0;
  bit   done1  = 0;

  logic        rst10, rd10, wr10, resp10, err10;
  lc3b_word    addr10;
  lc3b_l1_line wdata10, rdata10;
  logic [15:0] rdc10, wrc10;

  logic        rst1, rd1, wr1, resp1, err1;
  lc3b_word    addr1;
  lc3b_l1_line wdata1, rdata1;
  logic [15:0] rdc1, wrc1;

  pmem_responder #(.LATENCY(Lat10), .LINES(4096)) dut10 (
    .clk(clk), .rst_n(rst10), .pmem_read(rd10), .pmem_write(wr10),
    .pmem_address(addr10), .pmem_wdata(wdata10), .pmem_resp(resp10),
    .pmem_rdata(rdata10), .proto_error(err10), .rd_count(rdc10), .wr_count(wrc10)
  );

  pmem_responder #(.LATENCY(1), .LINES(4096)) dut1 (
    .clk(clk), .rst_n(rst1), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .proto_error(err1), .rd_count(rdc1), .wr_count(wrc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for the LATENCY=10 instance.
  lc3b_l1_line mem_model [int];
  lc3b_l1_line last_rd;
  int          rd_model, wr_model;
  bit          err_model;
  lc3b_l1_line sb_q [$];

  always @(negedge clk) begin
    if (resp10 === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 128'(resp10), 128'd0);
      end else begin
        check("sb_rdata", rdata10, sb_q.pop_front());
      end
    end
  end

  task automatic reset10();
    rd10 = 1'b0; wr10 = 1'b0; rst10 = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_resp", 128'(resp10), 128'd0);
    check("rst_rdata", rdata10, 128'd0);
    check("rst_err", 128'(err10), 128'd0);
    check("rst_rdcount", 128'(rdc10), 128'd0);
    check("rst_wrcount", 128'(wrc10), 128'd0);
    rst10 = 1'b1;
    last_rd = '0; rd_model = 0; wr_model = 0; err_model = 1'b0;
  endtask

  task automatic run_tx(input bit rd, input bit wr, input logic [15:0] addr,
                        input lc3b_l1_line wdata, input bit drop);
    int          idx;
    int          n;
    bit          seen;
    lc3b_l1_line exp;
    idx = int'(addr[15:4]);
    exp = wr ? last_rd : mem_model[idx];
    sb_q.push_back(exp);
    rd10 = rd; wr10 = wr; addr10 = addr; wdata10 = wdata;
    n = 0; seen = 1'b0;
    while (!seen && n < int'(Lat10) + 5) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (n == 2) begin
        addr10 = ~addr; wdata10 = ~wdata;
      end
      if (drop && n == 3) begin
        rd10 = 1'b0; wr10 = 1'b0;
      end
      if (resp10 === 1'b1) seen = 1'b1;
    end
    check("pulse_seen", 128'(seen), 128'd1);
    if (seen) check("pulse_cycle", 128'(n), 128'(Lat10));
    else if (sb_q.size() > 0) sb_q.delete(0);
    @(posedge clk);
    #1;
    rd10 = 1'b0; wr10 = 1'b0;
    if (wr) begin
      mem_model[idx] = wdata;
      wr_model++;
    end else begin
      last_rd = exp;
      rd_model++;
    end
    if ((rd && wr) || drop) err_model = 1'b1;
    @(negedge clk);
    check("pulse_width", 128'(resp10), 128'd0);
    check("rd_count", 128'(rdc10), 128'(rd_model));
    check("wr_count", 128'(wrc10), 128'(wr_model));
    check("proto_error", 128'(err10), 128'(err_model));
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    lc3b_l1_line wdata;
    bit          exp_err;
  } vec_t;

  localparam lc3b_l1_line LineA = 128'hA5A5_0004_1111_2222_3333_4444_5555_6666;
  localparam lc3b_l1_line D1    = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam lc3b_l1_line D2    = 128'hDEAD_BEEF_0000_1F30_CAFE_F00D_1234_5678;
  localparam lc3b_l1_line D3    = 128'h0200_0200_0200_0200_0200_0200_0200_0200;
  localparam lc3b_l1_line D4    = 128'h4444_3333_2222_1111_0300_0300_ABCD_EF01;
  localparam lc3b_l1_line D5    = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  initial begin : main10
    vec_t vecs [9];
    int   n;
    vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0123, wdata: D1,  exp_err: 1'b0};
    vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0120, wdata: '1,  exp_err: 1'b0};
    vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 16'h1F30, wdata: D2,  exp_err: 1'b0};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 16'h1F3C, wdata: '0,  exp_err: 1'b0};
    vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0040, wdata: D1,  exp_err: 1'b0};
    vecs[5] = '{rd: 1'b1, wr: 1'b1, addr: 16'h0200, wdata: D3,  exp_err: 1'b1};
    vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0200, wdata: '0,  exp_err: 1'b1};
    vecs[7] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0300, wdata: D4,  exp_err: 1'b1};
    vecs[8] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0123, wdata: D5,  exp_err: 1'b1};
    addr10 = '0; wdata10 = '0;

    // Load line 4, then reset: the array must keep it across reset.
    reset10();
    run_tx(1'b0, 1'b1, 16'h0040, LineA, 1'b0);
    reset10();
    run_tx(1'b1, 1'b0, 16'h0040, '0, 1'b0);
    check("first_read_line4", rdata10, LineA);

    for (int i = 0; i < 9; i++) begin
      run_tx(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
      check("vec_err", 128'(err10), 128'(vecs[i].exp_err));
    end

    // Reset in cycle 5 of a write to line 0x30: no pulse, no array update.
    wr10 = 1'b1; rd10 = 1'b0; addr10 = 16'h0300; wdata10 = D5;
    n = 0;
    while (n < 5) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    rst10 = 1'b0;
    @(posedge clk);
    #1;
    rst10 = 1'b1; wr10 = 1'b0;
    @(negedge clk);
    check("midrst_resp", 128'(resp10), 128'd0);
    check("midrst_rdata", rdata10, 128'd0);
    check("midrst_err", 128'(err10), 128'd0);
    check("midrst_rdcount", 128'(rdc10), 128'd0);
    check("midrst_wrcount", 128'(wrc10), 128'd0);
    last_rd = '0; rd_model = 0; wr_model = 0; err_model = 1'b0;
    repeat (15) @(negedge clk);
    run_tx(1'b1, 1'b0, 16'h0300, '0, 1'b0);
    check("midrst_line_kept", rdata10, D4);

    // Read dropped mid-flight still completes but flags an error.
    run_tx(1'b1, 1'b0, 16'h0123, '0, 1'b1);
    check("drop_err", 128'(err10), 128'd1);
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    done10 = 1'b1;
  end

  initial begin : main1
    int pulses;
    rst1 = 1'b0; rd1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0050; wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("l1_rst_resp", 128'(resp1), 128'd0);
    check("l1_rst_rdata", rdata1, 128'd0);
    check("l1_rst_rdcount", 128'(rdc1), 128'd0);
    rst1 = 1'b1;
    pulses = 0;
    for (int n = 1; n <= SatCycles; n++) begin
      @(posedge clk); @(negedge clk);
      if (resp1 === 1'b1) pulses++;
      if (n <= 6) check("b2b_pulse", 128'(resp1), 128'(n % 2));
      if (n == 6) check("b2b_rdcount", 128'(rdc1), 128'd3);
    end
    check("sat_pulses", 128'(pulses), 128'((SatCycles + 1) / 2));
    check("sat_rdcount", 128'(rdc1), 128'hFFFF);
    check("sat_wrcount", 128'(wrc1), 128'd0);
    check("sat_err", 128'(err1), 128'd0);
    rd1 = 1'b0;
    done1 = 1'b1;
  end

  initial begin : summary
    wait (done10 && done1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 The block SHALL declare parameter LATENCY, default 10, meaning cycles from request acceptance to pmem_resp (legal range 1..255).
REQ-002 The block SHALL declare parameter LINES, default 4096, meaning number of 128-bit lines stored (power of two, at most 4096).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port pmem_read, input, 1 bit: line read request, held by the initiator until pmem_resp.
REQ-006 The block SHALL have port pmem_write, input, 1 bit: line write request, held by the initiator until pmem_resp.
REQ-007 The block SHALL have port pmem_address, input, lc3b_word (16 bits): byte address; bits [3:0] ignored.
REQ-008 The block SHALL have port pmem_wdata, input, lc3b_l1_line (128 bits): write line data.
REQ-009 The block SHALL have port pmem_resp, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port pmem_rdata, output, lc3b_l1_line (128 bits): read line data.
REQ-011 The block SHALL have port proto_error, output, 1 bit: sticky protocol-violation flag.
REQ-012 The block SHALL have port rd_count, output, 16 bits: saturating count of completed reads.
REQ-013 The block SHALL have port wr_count, output, 16 bits: saturating count of completed writes.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-015 In IDLE with pmem_read or pmem_write high at a clock edge (cycle 0), the block SHALL latch op, line index (pmem_address[log2(LINES)+3:4], upper bits alias) and pmem_wdata, and leave IDLE.
REQ-016 On acceptance the block SHALL go to RESP if LATENCY=1, else to BUSY with a down-counter loaded with LATENCY-2.
REQ-017 BUSY SHALL decrement the counter each cycle and go to RESP when it reads 0.
REQ-018 pmem_resp SHALL be high exactly in cycle LATENCY after cycle 0, for exactly one cycle, with RESP returning to IDLE at the next edge.
REQ-019 During a read RESP cycle, pmem_rdata SHALL present the stored line; pmem_rdata SHALL hold that value until the next read's RESP.
REQ-020 A write SHALL update the array at the edge ending its RESP cycle; a following read of the same line SHALL return the new data.
REQ-021 Input changes during BUSY or RESP SHALL be ignored, because latched values govern.
REQ-022 A request still high in the IDLE cycle after RESP SHALL be accepted as a new transaction.
REQ-023 pmem_read and pmem_write both high at acceptance SHALL be serviced as a write and SHALL set proto_error.
REQ-024 A request dropped before pmem_resp SHALL set proto_error, and the transaction SHALL still complete with its pulse.
REQ-025 rd_count and wr_count SHALL increment at the edge ending each RESP cycle and saturate at 0xFFFF.

Reset
REQ-026 With rst_n low at an edge, the block SHALL set state to IDLE, counter to 0, pmem_resp 0, pmem_rdata 0, proto_error 0, rd_count 0 and wr_count 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction without a pulse and without an array write; array contents SHALL not be reset.
REQ-028 Requests SHALL be first sampled at the first edge with rst_n high.

Structure
REQ-029 lc3b_word and lc3b_l1_line SHALL come from the shared package lc3b_types; the pmem_state_t enum SHALL be added there.
REQ-030 The line storage SHALL be a sub-module pmem_array: one synchronous write port and one read port indexed by the latched line index.

Verification
REQ-031 The bench SHALL cover: reset, then read 0x0040 with LATENCY=10 -> pmem_resp only in cycle 10, pmem_rdata = initial line 4, rd_count=1.
REQ-032 The bench SHALL cover: write 0x0123, data 128'h0011..FF, then read 0x0120 -> read returns 128'h0011..FF, wr_count=1, rd_count=1.
REQ-033 The bench SHALL cover: LATENCY=1, back-to-back reads held continuously -> pulses in cycles 1, 3, 5, with no double service.
REQ-034 The bench SHALL cover: read and write both high at 0x0200 -> write performed, proto_error=1 and staying 1.
REQ-035 The bench SHALL cover: rst_n low in cycle 5 of a write -> no pulse, line unchanged, all outputs zero.
REQ-036 The bench SHALL cover: 65537 reads -> rd_count stays at 0xFFFF.
